// File: rtl/mem_wb_stage.sv
`default_nettype none
// =============================================================================
// Module   : mem_wb_stage
// Brief    : RV32 memory/write-back stage: load/store over a valid/ready data
//            port with lane steering and extension, plus register write-back.
// Revision : 1.0
// =============================================================================
module mem_wb_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_rs2_val,
    input  logic [1:0]        in_mem_op,
    input  logic [2:0]        in_wb_op,
    input  logic [2:0]        in_funct3,
    input  logic [REG_AW-1:0] in_rd,
    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic              dm_req_we,
    output logic [XLEN-1:0]   dm_req_addr,
    output logic [XLEN-1:0]   dm_req_wdata,
    output logic [3:0]        dm_req_wstrb,
    input  logic              dm_resp_valid,
    input  logic [XLEN-1:0]   dm_resp_rdata,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              busy_rd_valid,
    output logic [REG_AW-1:0] busy_rd,
    output logic              misalign_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] c_MEM_LD = 2'd1;
    localparam logic [1:0] c_MEM_ST = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_alu;
    logic [XLEN-1:0]   r_rs2;
    logic [1:0]        r_mem_op;
    logic [2:0]        r_wb_op;
    logic [2:0]        r_funct3;
    logic [REG_AW-1:0] r_rd;
    logic              r_wb_en;
    logic [REG_AW-1:0] r_wb_rd;
    logic [XLEN-1:0]   r_wb_data;
    logic              r_misalign;

    logic              w_accept;
    logic              w_in_mem;
    logic              w_in_misalign;
    logic              w_in_wb_act;
    logic              w_r_wb_act;
    logic [7:0]        w_ld_byte;
    logic [15:0]       w_ld_half;
    logic [XLEN-1:0]   w_ld_data;

    // Write-back value select; non-load instructions pass 0 as load data.
    function automatic logic [XLEN-1:0] f_wb_sel(input logic [2:0] op, input logic [XLEN-1:0] pc,
                                                 input logic [XLEN-1:0] alu, input logic [XLEN-1:0] ld);
        case (op)
            3'd1:    f_wb_sel = alu;
            3'd2:    f_wb_sel = ld;
            3'd3:    f_wb_sel = pc + XLEN'(4);
            default: f_wb_sel = '0;
        endcase
    endfunction

    assign w_accept      = in_valid && (r_state == S_IDLE);
    assign w_in_mem      = (in_mem_op == c_MEM_LD) || (in_mem_op == c_MEM_ST);
    assign w_in_misalign = ((in_funct3[1:0] == 2'd1) && in_alu_result[0]) ||
                           ((in_funct3[1:0] == 2'd2) && (in_alu_result[1:0] != 2'd0));
    assign w_in_wb_act   = (in_wb_op >= 3'd1) && (in_wb_op <= 3'd3);
    assign w_r_wb_act    = (r_wb_op >= 3'd1) && (r_wb_op <= 3'd3);

    assign w_ld_byte = dm_resp_rdata[{r_alu[1:0], 3'b000} +: 8];
    assign w_ld_half = r_alu[1] ? dm_resp_rdata[31:16] : dm_resp_rdata[15:0];

    always_comb begin
        case (r_funct3)
            3'd0:    w_ld_data = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
            3'd4:    w_ld_data = {{(XLEN-8){1'b0}}, w_ld_byte};
            3'd1:    w_ld_data = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
            3'd5:    w_ld_data = {{(XLEN-16){1'b0}}, w_ld_half};
            default: w_ld_data = dm_resp_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_in_mem && !w_in_misalign) w_state_nxt = S_REQ;
            S_REQ:  if (dm_req_ready) w_state_nxt = (r_mem_op == c_MEM_ST) ? S_IDLE : S_RESP;
            S_RESP: if (dm_resp_valid) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request fields are held at zero outside REQ so the bus is quiet when idle.
    always_comb begin
        in_ready      = (r_state == S_IDLE);
        dm_req_valid  = (r_state == S_REQ);
        dm_req_we     = 1'b0;
        dm_req_addr   = '0;
        dm_req_wdata  = '0;
        dm_req_wstrb  = 4'b0000;
        busy_rd_valid = ((r_state == S_REQ) || (r_state == S_RESP)) &&
                        (r_mem_op == c_MEM_LD) && w_r_wb_act && (r_rd != '0);
        busy_rd       = r_rd;
        if (r_state == S_REQ) begin
            dm_req_we   = (r_mem_op == c_MEM_ST);
            dm_req_addr = r_alu;
            case (r_funct3)
                3'd0: begin
                    dm_req_wdata = {4{r_rs2[7:0]}};
                    dm_req_wstrb = 4'b0001 << r_alu[1:0];
                end
                3'd1: begin
                    dm_req_wdata = {2{r_rs2[15:0]}};
                    dm_req_wstrb = 4'b0011 << r_alu[1:0];
                end
                default: begin
                    dm_req_wdata = r_rs2;
                    dm_req_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_alu      <= '0;
            r_rs2      <= '0;
            r_mem_op   <= '0;
            r_wb_op    <= '0;
            r_funct3   <= '0;
            r_rd       <= '0;
            r_wb_en    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_wb_en    <= 1'b0;
            r_misalign <= 1'b0;
            if (w_accept) begin
                r_pc     <= in_pc;
                r_alu    <= in_alu_result;
                r_rs2    <= in_rs2_val;
                r_mem_op <= in_mem_op;
                r_wb_op  <= in_wb_op;
                r_funct3 <= in_funct3;
                r_rd     <= in_rd;
                if (!w_in_mem) begin
                    r_wb_en   <= w_in_wb_act && (in_rd != '0);
                    r_wb_rd   <= in_rd;
                    r_wb_data <= f_wb_sel(in_wb_op, in_pc, in_alu_result, '0);
                end else if (w_in_misalign) begin
                    r_misalign <= 1'b1;
                end
            end else if ((r_state == S_RESP) && dm_resp_valid) begin
                r_wb_en   <= w_r_wb_act && (r_rd != '0);
                r_wb_rd   <= r_rd;
                r_wb_data <= f_wb_sel(r_wb_op, r_pc, r_alu, w_ld_data);
            end
        end
    end

    assign wb_en        = r_wb_en;
    assign wb_rd        = r_wb_rd;
    assign wb_data      = r_wb_data;
    assign misalign_err = r_misalign;

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory/write-back stage of the in-order RV32 pipeline; sits directly downstream of the execute stage.
- Consumes the execute-stage bundle: pc, rs2_val, alu_result, mem_op, wb_op, funct3, rd.
- Performs loads and stores over a valid/ready data-memory port, with sign/zero extension and byte-lane steering.
- Drives the register-file write port and reports a busy destination register for hazard detection.

Parameters:
- XLEN, 32, data/address width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  execute bundle valid.
- in_ready  out  1  stage can accept a bundle.
- in_pc  in  XLEN  instruction pc.
- in_alu_result  in  XLEN  ALU result / effective address.
- in_rs2_val  in  XLEN  store data.
- in_mem_op  in  2  0 none, 1 load, 2 store, 3 reserved (treated as none).
- in_wb_op  in  3  0 none, 1 alu_result, 2 load data, 3 pc+4, others none.
- in_funct3  in  3  access size/sign.
- in_rd  in  REG_AW  destination register.
- dm_req_valid  out  1  memory request valid.
- dm_req_ready  in  1  memory accepts request.
- dm_req_we  out  1  1 = store.
- dm_req_addr  out  XLEN  byte address.
- dm_req_wdata  out  XLEN  lane-replicated store data.
- dm_req_wstrb  out  4  byte enables.
- dm_resp_valid  in  1  load data valid.
- dm_resp_rdata  in  XLEN  aligned load word.
- wb_en  out  1  register write strobe.
- wb_rd  out  REG_AW  write index.
- wb_data  out  XLEN  write data.
- busy_rd_valid  out  1  a held instruction will still write busy_rd.
- busy_rd  out  REG_AW  pending destination register.
- misalign_err  out  1  one-cycle misaligned-access pulse.

Behaviour:
- Reset, asynchronous, rst_n low: state IDLE; all outputs 0 except in_ready = 1; latched bundle cleared.
- Reset mid-operation aborts any outstanding request. Nothing is written back. A dm_resp_valid arriving after reset is ignored.
- FSM states: IDLE, REQ, RESP.
- in_ready = 1 only in IDLE. A bundle is accepted on the cycle with in_valid && in_ready, and all fields are latched.
- Accept with mem_op none: stay IDLE. On the next cycle, wb outputs are registered with data per wb_op: alu_result, or pc+4 (mod 2^32). Throughput is 1 per cycle.
- Accept with a load/store:
  - Misaligned if funct3[1:0] = 1 and addr[0] = 1, or funct3[1:0] = 2 and addr[1:0] != 0.
  - Misaligned access: next cycle misalign_err = 1 for one cycle, no bus request, no writeback, stay IDLE.
  - Aligned access: go to REQ.
- REQ:
  - dm_req_valid = 1. addr, we, wdata and wstrb stay stable until dm_req_ready.
  - On handshake: a store returns to IDLE and completes with no writeback; a load goes to RESP.
  - dm_resp_valid is ignored in REQ.
- RESP: wait for dm_resp_valid. On its cycle, return to IDLE. The next cycle registers a writeback of the extended load data.
- Store strobes and data:
  - SB (funct3 0): wstrb = 0001 << addr[1:0]; wdata = rs2[7:0] x4.
  - SH (funct3 1): wstrb = 0011 << addr[1:0]; wdata = rs2[15:0] x2.
  - SW (funct3 2): wstrb = 1111.
  - Other funct3 values are treated as SW.
- Load extraction from dm_resp_rdata, lane selected by addr[1:0]:
  - LB (0) / LBU (4): byte, sign-extended / zero-extended.
  - LH (1) / LHU (5): halfword, sign-extended / zero-extended.
  - LW (2): full word.
  - Other funct3 values are treated as LW.
- wb_en is a one-cycle pulse. It is suppressed when rd = 0 or wb_op is none; wb_rd and wb_data still update.
- wb_op = 2 on a non-load instruction writes 0.
- busy_rd_valid = 1 in REQ/RESP when the held instruction is a load with wb_op != none and rd != 0. busy_rd = latched rd.

Test Plan:
- ALU op: alu_result = 0x1234, rd = 5, wb_op = 1 -> next cycle wb_en = 1, wb_rd = 5, wb_data = 0x00001234; in_ready stays 1, so back-to-back ops write back on consecutive cycles.
- LB: addr = 0x1003, rdata = 0x80FF_0000 -> wb_data = 0xFFFFFF80. LBU with the same address and rdata -> 0x00000080.
- SH: addr = 0x2002, rs2 = 0xAAAA_BEEF, dm_req_ready held low 3 cycles -> request stable for 4 cycles with wstrb = 1100, wdata = 0xBEEFBEEF; no wb_en; in_ready returns 1 after the handshake.
- Misaligned LW: addr = 0x1001 -> misalign_err pulses once, dm_req_valid never asserted, no wb_en.
- Load with rd = 0: LW completes, wb_en stays 0; busy_rd_valid stays 0 throughout.
- rst_n low while in RESP: outputs clear asynchronously, state IDLE; a later dm_resp_valid produces no writeback.
